// File: rtl/mux4way_rr.sv
// mux4way_rr: round-robin merge of four valid/ready channels into one registered output stage.
// Define MUX4WAY_COUNT_EN to add the 16-bit xfer_count of completed output transfers.
module mux4way_rr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic             c_valid,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic [WIDTH-1:0] c_data,
  input  logic [WIDTH-1:0] d_data,
  output logic             a_ready,
  output logic             b_ready,
  output logic             c_ready,
  output logic             d_ready,
`ifdef MUX4WAY_COUNT_EN
  output logic [15:0]      xfer_count,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);
  logic [3:0] vld, gnt;
  logic [WIDTH-1:0] din [4];
  logic can_load, found, load;
  logic [1:0] idx, pick;
  logic out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0] out_sel_q, out_sel_d, last_q, last_d;
  assign vld = {d_valid, c_valid, b_valid, a_valid};
  assign din[0] = a_data;
  assign din[1] = b_data;
  assign din[2] = c_data;
  assign din[3] = d_data;
  // Search starts just after the last winner; i=4 wraps back to the last winner itself.
  always_comb begin
    can_load = !out_valid_q | out_ready;
    found = 1'b0;
    pick = last_q;
    idx = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && vld[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
    load = found & can_load & !reset;
    gnt = load ? 4'b0001 << pick : 4'b0000;
    out_valid_d = can_load ? found : out_valid_q;
    out_data_d = load ? din[pick] : out_data_q;
    out_sel_d = load ? pick : out_sel_q;
    last_d = load ? pick : last_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sel_q <= 2'b00;
      last_q <= 2'b11;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sel_q <= out_sel_d;
      last_q <= last_d;
    end
  end
  assign {d_ready, c_ready, b_ready, a_ready} = gnt;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;
`ifdef MUX4WAY_COUNT_EN
  logic [15:0] xfer_count_q, xfer_count_d;
  always_comb xfer_count_d = xfer_count_q + 16'(out_valid_q & out_ready);
  always_ff @(posedge clk) begin
    if (reset) xfer_count_q <= '0;
    else xfer_count_q <= xfer_count_d;
  end
  assign xfer_count = xfer_count_q;
`endif
endmodule

// File: doc/mux4way_rr.md
Name: mux4way_rr

Overview:
- Sequential counterpart of the 4-way demux: merges four independent input channels (a, b, c, d) onto one output channel.
- Uses round-robin arbitration and a one-entry registered output stage with valid/ready handshakes.
- out_sel reports which input the current output word came from, so a downstream dmux4way can route responses back.
- Sits between four producers and a single shared consumer.

Parameters:
- WIDTH, 16, data width of every input and output channel.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- a_valid, b_valid, c_valid, d_valid  input  1 each  input channel holds a word.
- a_data, b_data, c_data, d_data  input  WIDTH each  input channel payload.
- a_ready, b_ready, c_ready, d_ready  output  1 each  combinational grant; word accepted this cycle when valid & ready.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered payload.
- out_sel  output  2  source of out_data: 00=a, 01=b, 10=c, 11=d.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready.

Behaviour:
- Single clock domain; reset is synchronous and active-high, sampled on rising clk.
- Reset values:
  - out_valid=0, out_data=0, out_sel=00.
  - Internal last-grant pointer = 11, so a has highest priority on the first arbitration.
- Output state (implicit FSM):
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = !out_valid | out_ready.
- Arbitration (combinational, same cycle):
  - When can_load=1, search ports in order last+1, last+2, last+3, last (mod 4).
  - The first port with valid=1 is granted: its x_ready=1; all other x_ready=0.
  - When can_load=0, all x_ready=0.
- At most one x_ready is high in any cycle; ready does not depend on that port's own valid beyond selection.
- On a grant, at the next edge:
  - out_data <= granted data; out_sel <= granted index; out_valid <= 1; last <= granted index.
- If can_load=1 and no input is valid: out_valid <= 0. out_data and out_sel hold their old values; don't-care, but must not change in this implementation.
- If out_valid=1 and out_ready=0: out_data, out_sel and out_valid hold; no input is granted.
- Simultaneous drain and load (out_valid=1, out_ready=1, one or more inputs valid): new word loads in the same edge. Full throughput is 1 word/cycle.
- Latency: input accepted at edge N appears on out_* after edge N (visible in cycle N+1).
- Pointer wraps 11 -> 00.
- Reset mid-operation:
  - Any held word is discarded; out_valid=0 the cycle after reset is sampled.
  - All x_ready=0 while reset=1.
  - Pointer returns to 11.
- Fairness: with all four valid continuously and out_ready=1, grant order is a,b,c,d,a,... (one grant per cycle).
- No X propagation: out_data is never loaded from an unselected channel.

Optional Feature:
- Macro: MUX4WAY_COUNT_EN.
- Defined:
  - Extra output xfer_count (output, 16 bits): number of completed output transfers (out_valid & out_ready).
  - Increments by 1 per transfer; wraps FFFF -> 0000; reset value 0000.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset held 2 cycles, all valid=0 -> out_valid=0, out_sel=00, out_data=0, all x_ready=0 during reset.
- Only c_valid=1, c_data=16'h00C3, out_ready=1 -> c_ready=1 that cycle; next cycle out_valid=1, out_data=00C3, out_sel=10.
- All four valid (a=0001, b=0002, c=0003, d=0004) held, out_ready=1 for 6 cycles -> out_sel sequence 00,01,10,11,00,01; out_data follows 0001..0004; one word per cycle.
- Backpressure:
  - out_ready=0 with word 0002/sel 01 held and a_valid=1 for 3 cycles -> out_* stable; a_ready=0.
  - Then out_ready=1 -> a granted same cycle; next out_sel=00.
- Reset asserted while out_valid=1 and b,d valid -> next cycle out_valid=0; after release the first grant goes to a if valid, else b.
- With MUX4WAY_COUNT_EN defined, 5 transfers then 1 stalled cycle -> xfer_count=5. Preload by driving 65535 transfers plus 1 more -> xfer_count=0.
